// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port cache-to-memory arbiter, one outstanding transaction; define MEM_ARB_ROUND_ROBIN_EN for round-robin priority
module mem_port_arbiter #(
  parameter int addressSize = 64,
  parameter int blockSize   = 256
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [1:0]               portReq_i,
  input  logic [1:0]               portIsWrite_i,
  input  logic [2*addressSize-1:0] portAddress_i,
  input  logic [2*blockSize-1:0]   portData_i,
  output logic [1:0]               portGrant_o,
  output logic [1:0]               respValid_o,
  output logic [blockSize-1:0]     respBlock_o,
  output logic [addressSize-1:0]   respAddress_o,
  output logic [addressSize-1:0]   address_o,
  output logic [blockSize-1:0]     data_o,
  output logic                     requestEnable_o,
  output logic                     isMemWrite_o,
  input  logic [blockSize-1:0]     block_i,
  input  logic [addressSize-1:0]   blockAddress_i,
  input  logic                     blockOutEnable_i
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t                 state_q, state_d;
  logic                   win_q, win_d, wr_q, wr_d, boe_q, pick, done;
  logic [1:0]             grant_q, grant_d;
  logic [addressSize-1:0] addr_q, addr_d, raddr_q, raddr_d;
  logic [blockSize-1:0]   data_q, data_d, rblk_q, rblk_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q;
  assign pick = &portReq_i ? ~last_q : portReq_i[1];
  // remember the most recent winner so the other port gets the next tie
  always_ff @(posedge clock_i)
    if (!reset_i) last_q <= 1'b1;
    else if (state_q == IDLE && |portReq_i) last_q <= pick;
`else
  assign pick = portReq_i[1];
`endif
  assign done = state_q == WAIT && blockOutEnable_i && !boe_q;
  // next-state: arbitrate in IDLE, strobe in ISSUE, wait for the completion edge, respond
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    raddr_d = raddr_q;
    rblk_d  = rblk_q;
    grant_d = 2'b00;
    case (state_q)
      IDLE: if (|portReq_i) begin
        state_d = ISSUE;
        win_d   = pick;
        grant_d = pick ? 2'b10 : 2'b01;
        wr_d    = portIsWrite_i[pick];
        addr_d  = pick ? portAddress_i[2*addressSize-1:addressSize] : portAddress_i[addressSize-1:0];
        data_d  = pick ? portData_i[2*blockSize-1:blockSize] : portData_i[blockSize-1:0];
      end
      ISSUE: state_d = WAIT;
      WAIT: if (done) begin
        state_d = RESPOND;
        raddr_d = blockAddress_i;
        rblk_d  = block_i;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; the completion history is sampled every cycle
  always_ff @(posedge clock_i)
    if (!reset_i) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      wr_q    <= 1'b0;
      boe_q   <= 1'b0;
      grant_q <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
      raddr_q <= '0;
      rblk_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      boe_q   <= blockOutEnable_i;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      raddr_q <= raddr_d;
      rblk_q  <= rblk_d;
    end
  assign portGrant_o     = grant_q;
  assign respValid_o     = state_q == RESPOND ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign requestEnable_o = state_q == ISSUE;
  assign address_o       = addr_q;
  assign data_o          = data_q;
  assign isMemWrite_o    = wr_q;
  assign respBlock_o     = rblk_q;
  assign respAddress_o   = raddr_q;
endmodule
